memoria_dados_bytes: RTL

Parametrised, byte-addressable data memory for the single-cycle/multicycle CPU datapath. It replaces the fixed 101-word, word-only store. It adds a request/acknowledge handshake, byte/halfword/word access with per-lane write enables, sign- or zero-extended loads, and registered read data. It sits between the ALU address output and the write-back mux, driven by the control unit's memWrite and access-size decode.

---
 rtl/memoria_dados_bytes.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memoria_dados_bytes.sv
// Byte-addressable data memory with req/pronto handshake, sub-word access and registered loads.
// Optional address/alignment checking is enabled by defining MEMORIA_DADOS_CHECK_EN.
module memoria_dados_bytes #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 26
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              memWrite,
   input  logic [1:0]        tamanho,
   input  logic              sinalizado,
   input  logic [ADDR_W-1:0] endereco,
   input  logic [DATA_W-1:0] dado_Escrito,
   output logic [DATA_W-1:0] dado_Lido,
   output logic              pronto,
   output logic              ocupado,
   output logic              erro
);

   localparam int IDX_W = $clog2(DEPTH);

   // Handshake: a request is accepted on any edge where the FSM is in OCIOSO and req=1;
   // the following cycle (RESPOSTA) carries pronto=1 with erro/dado_Lido valid, and req is ignored.
   typedef enum logic {OCIOSO = 1'b0, RESPOSTA = 1'b1} estado_t;
   estado_t estado;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [IDX_W-1:0]  indice;
   logic              rejeita;
   logic              aceita;
   logic              grava;
   logic [3:0]        lanes;
   logic [DATA_W-1:0] dado_alinhado;
   logic [DATA_W-1:0] palavra;
   logic [7:0]        byte_sel;
   logic [15:0]       meia_sel;
   logic [DATA_W-1:0] valor_lido;

   assign indice = endereco[IDX_W+1:2];

`ifdef MEMORIA_DADOS_CHECK_EN
   localparam logic [ADDR_W-3:0] LIMITE = (ADDR_W-2)'(DEPTH);

   assign rejeita = (endereco[ADDR_W-1:2] >= LIMITE)
                 || (tamanho == 2'b01 && endereco[0])
                 || (tamanho == 2'b10 && endereco[1:0] != 2'b00)
                 || (tamanho == 2'b11);
`else
   // Without checking, high address bits simply alias onto the implemented words.
   logic unused_endereco_alto;
   assign unused_endereco_alto = ^endereco[ADDR_W-1:IDX_W+2];
   assign rejeita = 1'b0;
`endif

   assign aceita = (estado == OCIOSO) && req;
   assign grava  = !reset && aceita && memWrite && !rejeita;

   // Store data is right-aligned on the port; replicate it so every lane sees its slice.
   always_comb begin
      lanes         = 4'b1111;
      dado_alinhado = dado_Escrito;
      case (tamanho)
         2'b00: begin
            lanes         = 4'b0001 << endereco[1:0];
            dado_alinhado = {4{dado_Escrito[7:0]}};
         end
         2'b01: begin
            lanes         = endereco[1] ? 4'b1100 : 4'b0011;
            dado_alinhado = {2{dado_Escrito[15:0]}};
         end
         default: begin
            lanes         = 4'b1111;
            dado_alinhado = dado_Escrito;
         end
      endcase
   end

   always_comb begin
      palavra    = mem[indice];
      byte_sel   = palavra[8*endereco[1:0] +: 8];
      meia_sel   = endereco[1] ? palavra[31:16] : palavra[15:0];
      valor_lido = palavra;
      case (tamanho)
         2'b00: valor_lido = sinalizado ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                                        : {{(DATA_W-8){1'b0}}, byte_sel};
         2'b01: valor_lido = sinalizado ? {{(DATA_W-16){meia_sel[15]}}, meia_sel}
                                        : {{(DATA_W-16){1'b0}}, meia_sel};
         default: valor_lido = palavra;
      endcase
   end

   // Memory array has no reset; contents survive a reset of the control path.
   always_ff @(posedge clock) begin
      if (grava) begin
         for (int i = 0; i < 4; i++) begin
            if (lanes[i]) mem[indice][8*i +: 8] <= dado_alinhado[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado    <= OCIOSO;
         pronto    <= 1'b0;
         ocupado   <= 1'b0;
         erro      <= 1'b0;
         dado_Lido <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (req) begin
                  estado  <= RESPOSTA;
                  pronto  <= 1'b1;
                  ocupado <= 1'b1;
                  erro    <= rejeita;
                  if (rejeita)       dado_Lido <= '0;
                  else if (!memWrite) dado_Lido <= valor_lido;
               end else begin
                  pronto  <= 1'b0;
                  ocupado <= 1'b0;
                  erro    <= 1'b0;
               end
            end
            RESPOSTA: begin
               estado  <= OCIOSO;
               pronto  <= 1'b0;
               ocupado <= 1'b0;
               erro    <= 1'b0;
            end
            default: begin
               estado  <= OCIOSO;
               pronto  <= 1'b0;
               ocupado <= 1'b0;
               erro    <= 1'b0;
            end
         endcase
      end
   end

endmodule
